// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse
// Purpose  : Turns one active-low, bouncy pushbutton into a clean debounced
//            level plus single-cycle press and release pulses. All outputs
//            are in the Clock domain. Pressed is meant to drive the enable of
//            a downstream counter stage.
// Ports    : Clock    - system clock, all state updates on the rising edge
//            Resetn   - asynchronous active-low reset
//            Key_n    - raw pushbutton, 0 = pressed, asynchronous and bouncy
//            Level    - debounced pressed level, 1 = pressed (registered)
//            Pressed  - one-cycle pulse on an accepted press (registered)
//            Released - one-cycle pulse on an accepted release (registered)
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic Key_n,
   output logic Level,
   output logic Pressed,
   output logic Released
);

   localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_PRESS_WAIT   = 2'd1,
      S_HELD         = 2'd2,
      S_RELEASE_WAIT = 2'd3
   } state_t;

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_key;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 r_level;
   logic                 r_pressed;
   logic                 r_released;
   logic                 w_level_nxt;
   logic                 w_pressed_nxt;
   logic                 w_released_nxt;

   // Two-flop synchroniser; resets to the released value so a key held
   // through reset is seen as a fresh press afterwards.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= Key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_key = ~r_sync2;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_level    <= 1'b0;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_level    <= w_level_nxt;
         r_pressed  <= w_pressed_nxt;
         r_released <= w_released_nxt;
      end
   end

   // The counter only advances while the candidate value stays put; it is
   // cleared on entry to each wait state and the accepting transition fires
   // at DEBOUNCE_CYCLES-1, so it can never wrap.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pressed_nxt  = 1'b0;
      w_released_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_key) begin
               w_state_nxt = S_PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_PRESS_WAIT: begin
            if (!w_key) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt   = S_HELD;
               w_pressed_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
         S_HELD: begin
            if (!w_key) begin
               w_state_nxt = S_RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_RELEASE_WAIT: begin
            if (w_key) begin
               w_state_nxt = S_HELD;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt    = S_IDLE;
               w_released_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Level is registered from the next state so it moves in the same
      // cycle as the corresponding pulse.
      w_level_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_WAIT);
   end

   assign Level    = r_level;
   assign Pressed  = r_pressed;
   assign Released = r_released;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_pulse
// Purpose  : Self-checking bench for key_debounce_pulse with a 4-cycle
//            debounce window. A reference model pushes expected pulse events
//            into a queue; a monitor pops them as the DUT pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

   localparam int D = 4;

   logic Clock;
   logic Resetn;
   logic Key_n;
   logic Level;
   logic Pressed;
   logic Released;

   key_debounce_pulse #(
      .DEBOUNCE_CYCLES(D),
      .CNT_WIDTH      (3)
   ) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .Key_n   (Key_n),
      .Level   (Level),
      .Pressed (Pressed),
      .Released(Released)
   );

   typedef struct {
      bit          is_press;
      int unsigned edge_i;
   } ev_t;

   ev_t         exp_q[$];
   int unsigned edge_n;
   int          checks;
   int          errors;
   bit          m_level;
   int unsigned last_press_edge;
   int unsigned last_rel_edge;
   int          press_cnt;
   int          rel_cnt;
   logic [3:0]  tb_count;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Downstream 4-bit counter enabled by Pressed.
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) tb_count <= 4'd0;
      else if (Pressed) tb_count <= tb_count + 4'd1;
   end

   // Reference model: the key seen by the debouncer is the raw sample from
   // two edges earlier. A change is accepted once D+1 consecutive seen
   // samples differ from the current debounced level.
   initial begin : model
      bit h1, h2, seen;
      int run;
      h1 = 1'b1; h2 = 1'b1; run = 0;
      m_level = 1'b0;
      edge_n  = 0;
      forever begin
         @(posedge Clock or negedge Resetn);
         if (!Resetn) begin
            h1 = 1'b1; h2 = 1'b1; run = 0;
            m_level = 1'b0;
            exp_q.delete();
         end else begin
            edge_n = edge_n + 1;
            seen = ~h2;
            h2 = h1;
            h1 = Key_n;
            if (seen != m_level) begin
               run = run + 1;
               if (run == D + 1) begin
                  ev_t e;
                  m_level = seen;
                  run = 0;
                  e.is_press = seen;
                  e.edge_i   = edge_n;
                  exp_q.push_back(e);
               end
            end else begin
               run = 0;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin : monitor
      forever begin
         @(negedge Clock);
         if (!Resetn) begin
            checks++;
            if (Level || Pressed || Released) begin
               errors++;
               $display("FAIL reset_outputs: got L=%b P=%b R=%b want 000", Level, Pressed, Released);
            end
         end else begin
            checks++;
            if (Level !== m_level) begin
               errors++;
               $display("FAIL level: edge %0d got %b want %b", edge_n, Level, m_level);
            end
            if (Pressed && Released) begin
               errors++;
               $display("FAIL both_pulses: edge %0d Pressed and Released high together", edge_n);
            end
            if (Pressed || Released) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pulse: edge %0d P=%b R=%b, none expected", edge_n, Pressed, Released);
               end else begin
                  ev_t e;
                  e = exp_q.pop_front();
                  if (e.is_press !== Pressed || e.edge_i != edge_n) begin
                     errors++;
                     $display("FAIL pulse: got press=%b at edge %0d, want press=%b at edge %0d",
                              Pressed, edge_n, e.is_press, e.edge_i);
                  end
               end
               if (Pressed) begin press_cnt++; last_press_edge = edge_n; end
               if (Released) begin rel_cnt++; last_rel_edge = edge_n; end
            end
            if (exp_q.size() > 0 && exp_q[0].edge_i < edge_n) begin
               ev_t e;
               e = exp_q.pop_front();
               checks++;
               errors++;
               $display("FAIL missed_pulse: press=%b expected at edge %0d, still absent at edge %0d",
                        e.is_press, e.edge_i, edge_n);
            end
         end
      end
   end

   task automatic hold(input logic v, input int n);
      @(negedge Clock);
      Key_n = v;
      repeat (n - 1) @(negedge Clock);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge Clock);
      #2 Resetn = 1'b0;
      @(negedge Clock);
      #2 Resetn = 1'b1;
   endtask

   initial begin : stim
      int k, p0, r0;
      checks = 0; errors = 0;
      press_cnt = 0; rel_cnt = 0;
      last_press_edge = 0; last_rel_edge = 0;

      // 1: reset with key held, then re-qualification.
      Resetn = 1'b0;
      Key_n  = 1'b0;
      #1;
      check_int("reset_level",    int'(Level),    0);
      check_int("reset_pressed",  int'(Pressed),  0);
      check_int("reset_released", int'(Released), 0);
      @(negedge Clock);
      #2 Resetn = 1'b1;
      k = int'(edge_n) + 1;
      repeat (14) @(negedge Clock);
      check_int("t1_press_edge", int'(last_press_edge), k + 6);
      check_int("t1_press_count", press_cnt, 1);
      hold(1'b1, 15);

      // 2: clean press held 20 cycles.
      p0 = press_cnt;
      @(negedge Clock);
      Key_n = 1'b0;
      k = int'(edge_n) + 1;
      repeat (19) @(negedge Clock);
      check_int("t2_press_edge", int'(last_press_edge), k + 6);
      check_int("t2_single_press", press_cnt - p0, 1);
      check_int("t2_level", int'(Level), 1);

      // 4: release from HELD, then a 2-cycle glitch while held.
      r0 = rel_cnt;
      @(negedge Clock);
      Key_n = 1'b1;
      k = int'(edge_n) + 1;
      repeat (19) @(negedge Clock);
      check_int("t4_release_edge", int'(last_rel_edge), k + 6);
      check_int("t4_single_release", rel_cnt - r0, 1);
      hold(1'b0, 15);
      r0 = rel_cnt;
      hold(1'b1, 2);
      hold(1'b0, 12);
      check_int("t4_glitch_no_release", rel_cnt - r0, 0);
      check_int("t4_glitch_level", int'(Level), 1);
      hold(1'b1, 15);

      // 3: bounce shorter than the window.
      p0 = press_cnt;
      hold(1'b0, 3);
      hold(1'b1, 1);
      hold(1'b0, 2);
      hold(1'b1, 12);
      check_int("t3_bounce_no_press", press_cnt - p0, 0);
      check_int("t3_bounce_level", int'(Level), 0);

      // 5: counter chain, 17 presses.
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         hold(1'b0, 10);
         hold(1'b1, 10);
         check_int($sformatf("t5_count_%0d", i), int'(tb_count), i % 16);
      end

      // 6: reset while counting in PRESS_WAIT.
      p0 = press_cnt;
      @(negedge Clock);
      Key_n = 1'b0;
      repeat (5) @(posedge Clock);
      #2 Resetn = 1'b0;
      #1;
      check_int("t6_reset_level", int'(Level), 0);
      @(negedge Clock);
      #2 Resetn = 1'b1;
      k = int'(edge_n) + 1;
      repeat (14) @(negedge Clock);
      check_int("t6_press_edge", int'(last_press_edge), k + 6);
      check_int("t6_single_press", press_cnt - p0, 1);
      hold(1'b1, 15);

      // Randomised bouncy activity against the model.
      for (int s = 0; s < 200; s++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end
      hold(1'b1, 20);
      check_int("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
